// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS32 general-purpose register file.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam word_t     ZERO_WORD    = '0;
  localparam reg_addr_t NOP_REG_ADDR = '0;

  // $0 is hard-wired to zero; NOP bubbles target it as well.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == NOP_REG_ADDR;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Write-back (MEM/WB) write port and the two decode-stage read ports.
interface regfile_if;
  import regfile_pkg::*;

  logic      we;
  reg_addr_t waddr;
  word_t     wdata;
  logic      re1;
  reg_addr_t raddr1;
  word_t     rdata1;
  logic      re2;
  reg_addr_t raddr2;
  word_t     rdata2;

  modport master (
    output we, waddr, wdata,
    output re1, raddr1,
    output re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1,
    input  re2, raddr2,
    output rdata1, rdata2
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port. Optional macro: REGFILE_BYPASS_EN enables
// same-cycle forwarding of the write-back value to this port.
module regfile_rd_port
  import regfile_pkg::*;
(
  input  logic      rst,
  input  logic      re,
  input  reg_addr_t raddr,
  input  logic      we,
  input  reg_addr_t waddr,
  input  word_t     wdata,
  input  word_t     mem_data,
  output word_t     rdata
);

`ifndef REGFILE_BYPASS_EN
  // Write-port inputs only feed the bypass path.
  logic unused_bypass;
  assign unused_bypass = ^{we, waddr, wdata};
`endif

  // Priority mux: reset, disabled port, $0, bypass, then array contents.
  always_comb begin
    rdata = ZERO_WORD;
    if (rst || !re || is_zero_reg(raddr)) begin
      rdata = ZERO_WORD;
    end
`ifdef REGFILE_BYPASS_EN
    else if (we && (waddr == raddr)) begin
      rdata = wdata;
    end
`endif
    else begin
      rdata = mem_data;
    end
  end

endmodule

// File: rtl/regfile.sv
// MIPS32 register file: 32x32 storage, one write port from MEM/WB,
// two combinational read ports to decode. Optional macro REGFILE_BYPASS_EN
// forwards the value being written to both read ports in the same cycle.
module regfile
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  regfile_if.slave bus
);

  word_t mem [NREG];

  // Storage update: reset clears everything and drops a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[ADDR_W'(i)] <= ZERO_WORD;
      end
    end else if (bus.we && !is_zero_reg(bus.waddr)) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  regfile_rd_port u_rd_port1 (
    .rst      (rst),
    .re       (bus.re1),
    .raddr    (bus.raddr1),
    .we       (bus.we),
    .waddr    (bus.waddr),
    .wdata    (bus.wdata),
    .mem_data (mem[bus.raddr1]),
    .rdata    (bus.rdata1)
  );

  regfile_rd_port u_rd_port2 (
    .rst      (rst),
    .re       (bus.re2),
    .raddr    (bus.raddr2),
    .we       (bus.we),
    .waddr    (bus.waddr),
    .wdata    (bus.wdata),
    .mem_data (mem[bus.raddr2]),
    .rdata    (bus.rdata2)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized
// traffic checked against an architectural register model.
module tb_regfile;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] model [32];

  regfile_if bus ();

  regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view of a read port at the current inputs.
  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] addr);
    if (rst) return 32'h0;
    if (!en) return 32'h0;
    if (addr == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we && bus.waddr == addr) return bus.wdata;
`endif
    return model[addr];
  endfunction

  // Advance one clock and apply the architectural update rule to the model.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (bus.we && bus.waddr != 5'd0) begin
      model[bus.waddr] = bus.wdata;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
    bus.we = w; bus.waddr = wa; bus.wdata = wd;
    bus.re1 = e1; bus.raddr1 = a1;
    bus.re2 = e2; bus.raddr2 = a2;
    #2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 5'd0, 1'b0, 5'd0);
      step();
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'($urandom_range(1, 31)), 1'b1, 5'($urandom_range(1, 31)));
      checks++;
      if (bus.rdata1 !== 32'h0) begin
        errors++; $display("FAIL reset_during_p1 got %h want %h", bus.rdata1, 32'h0);
      end
      checks++;
      if (bus.rdata2 !== 32'h0) begin
        errors++; $display("FAIL reset_during_p2 got %h want %h", bus.rdata2, 32'h0);
      end
      step();
    end
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(a));
      checks++;
      if (bus.rdata1 !== 32'h0) begin
        errors++; $display("FAIL reset_clear_p1 reg %0d got %h want %h", a, bus.rdata1, 32'h0);
      end
      checks++;
      if (bus.rdata2 !== 32'h0) begin
        errors++; $display("FAIL reset_clear_p2 reg %0d got %h want %h", a, bus.rdata2, 32'h0);
      end
      step();
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    checks++;
    if (bus.rdata1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read_p1 got %h want %h", bus.rdata1, 32'hDEADBEEF);
    end
    checks++;
    if (bus.rdata2 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read_p2 got %h want %h", bus.rdata2, 32'hDEADBEEF);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5);
    checks++;
    if (bus.rdata1 !== 32'h0) begin
      errors++; $display("FAIL read_disabled_p1 got %h want %h", bus.rdata1, 32'h0);
    end
    checks++;
    if (bus.rdata2 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_indep_p2 got %h want %h", bus.rdata2, 32'hDEADBEEF);
    end
    step();
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    checks++;
    if (bus.rdata1 !== 32'h0) begin
      errors++; $display("FAIL zero_same_cycle_p1 got %h want %h", bus.rdata1, 32'h0);
    end
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    checks++;
    if (bus.rdata1 !== 32'h0) begin
      errors++; $display("FAIL zero_reg_p1 got %h want %h", bus.rdata1, 32'h0);
    end
    checks++;
    if (bus.rdata2 !== 32'h0) begin
      errors++; $display("FAIL zero_reg_p2 got %h want %h", bus.rdata2, 32'h0);
    end
    step();
  endtask

  task automatic test_hazard();
    logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'h22222222;
`else
    want = 32'h11111111;
`endif
    drive(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 1'b1, 5'd7);
    checks++;
    if (bus.rdata1 !== want) begin
      errors++; $display("FAIL hazard_same_p1 got %h want %h", bus.rdata1, want);
    end
    checks++;
    if (bus.rdata2 !== want) begin
      errors++; $display("FAIL hazard_same_p2 got %h want %h", bus.rdata2, want);
    end
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    checks++;
    if (bus.rdata1 !== 32'h22222222) begin
      errors++; $display("FAIL hazard_next_p1 got %h want %h", bus.rdata1, 32'h22222222);
    end
    checks++;
    if (bus.rdata2 !== 32'h22222222) begin
      errors++; $display("FAIL hazard_next_p2 got %h want %h", bus.rdata2, 32'h22222222);
    end
    step();
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 5'd3, 32'hAAAA5555, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h12345678, 1'b1, 5'd3, 1'b1, 5'd3);
    checks++;
    if (bus.rdata1 !== 32'h0) begin
      errors++; $display("FAIL rst_prio_during_p1 got %h want %h", bus.rdata1, 32'h0);
    end
    checks++;
    if (bus.rdata2 !== 32'h0) begin
      errors++; $display("FAIL rst_prio_during_p2 got %h want %h", bus.rdata2, 32'h0);
    end
    step();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
    checks++;
    if (bus.rdata1 !== 32'h0) begin
      errors++; $display("FAIL rst_prio_after_p1 got %h want %h", bus.rdata1, 32'h0);
    end
    checks++;
    if (bus.rdata2 !== 32'h0) begin
      errors++; $display("FAIL rst_prio_after_p2 got %h want %h", bus.rdata2, 32'h0);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] e1;
    logic [31:0] e2;
    logic [4:0]  wa;
    logic [4:0]  a1;
    logic [4:0]  a2;
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom,
            ($urandom_range(0, 7) != 0), a1,
            ($urandom_range(0, 7) != 0), a2);
      e1 = exp_rd(bus.re1, bus.raddr1);
      e2 = exp_rd(bus.re2, bus.raddr2);
      checks++;
      if (bus.rdata1 !== e1) begin
        errors++; $display("FAIL random_p1 cyc %0d addr %0d got %h want %h", n, a1, bus.rdata1, e1);
      end
      checks++;
      if (bus.rdata2 !== e2) begin
        errors++; $display("FAIL random_p2 cyc %0d addr %0d got %h want %h", n, a2, bus.rdata2, e2);
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'h0;
    bus.re1 = 1'b0; bus.raddr1 = 5'd0;
    bus.re2 = 1'b0; bus.raddr2 = 5'd0;
    step();
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_hazard();
    test_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file of the MIPS32 five-stage pipeline. It holds architectural registers $0-$31 and takes its write port from the write-back side of the MEM/WB pipeline register, i.e. the destination address, write-enable and result that the memory stage forwards. It serves two read ports to the decode stage. Register $0 is hard-wired to zero. Writes are committed on the clock edge; reads are combinational, so decode sees operands in the same cycle it presents addresses.

## Interface
- `DATA_W`, 32, register width (`RegBus`)
- `ADDR_W`, 5, register address width (`RegAddrBus`)
- `NREG`, 32, number of registers (`RegNum`); must equal 2**ADDR_W
- `clk`  in  1  pipeline clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous and active-high (`RstEnable` = 1'b1)
- `we`  in  1  write enable from MEM/WB (`wreg`)
- `waddr`  in  ADDR_W  destination register from MEM/WB (`wd`)
- `wdata`  in  DATA_W  result from MEM/WB
- `re1`  in  1  read-port-1 enable from decode
- `raddr1`  in  ADDR_W  read-port-1 address
- `rdata1`  out  DATA_W  read-port-1 data
- `re2`  in  1  read-port-2 enable
- `raddr2`  in  ADDR_W  read-port-2 address
- `rdata2`  out  DATA_W  read-port-2 data

## Operation
- Storage: NREG × DATA_W flops; entry 0 is never written. Synthesis may drop it.
- Write: at a rising `clk` with `rst`=0, `we`=1 and `waddr`≠0, `mem[waddr]` ← `wdata`. `we`=1 with `waddr`=0 is a legal no-op. This covers NOP bubbles that carry `NOPRegAddr`.
- Reset: a rising `clk` with `rst`=1 clears all entries to `ZeroWord`. A write presented in that same cycle is discarded.
- Read port n, evaluated in priority order:
  - If `rst`=1: `rdatan`=0.
  - Else if `ren`=0: `rdatan`=0.
  - Else if `raddrn`=0: `rdatan`=0.
  - Else if bypass is compiled in, `we`=1 and `waddr`=`raddrn`: `rdatan`=`wdata`.
  - Else: `rdatan`=`mem[raddrn]`.
- The two ports are fully independent. Both may address the same register, including the one being written, and both return the same value.
- No X propagation: every output path resolves to a defined value for any input combination with `rst` asserted or deasserted.

## Timing
- Write latency: one edge. Data written at edge k is visible to a plain array read from edge k onward.
- Read latency: zero cycles, combinational from `raddrn`/`ren`/`rst`. With bypass compiled in, there is also a combinational path from `we`/`waddr`/`wdata`.
- Reset: outputs are 0 combinationally while `rst`=1. The array is cleared at the first edge with `rst`=1. Deasserting `rst` mid-sequence resumes normal writes at the next edge; no state survives.
- The block has no stall input. MEM/WB holding `we`=1 across a stall rewrites the same value, which is harmless.

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle write-to-read bypass is active on both ports. An instruction in decode reads the value being written back in that cycle. This removes the distance-3 hazard.
- Not defined: reads always return the array contents. A read of `waddr` in the write cycle returns the old value, and the decode-stage forwarding network must cover the distance-3 case.

## Structure
- These shared constants live in `define.v`: `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`, `ZeroWord`, `RstEnable`, `WriteEnable`, `ReadEnable`, `NOPRegAddr`. The block adds no new global constants.
- One sub-module is natural: `regfile_rd_port`, which holds the priority mux for a single read port including the optional bypass. It is instantiated twice, so both ports are guaranteed to use identical logic.

## Test plan
- Reset: hold `rst`=1 for 2 cycles after random writes. Then read all 32 registers on both ports → every read returns 0x00000000.
- Write/read: write $5 ← 0xDEADBEEF, then next cycle `re1`=1, `raddr1`=5 → `rdata1`=0xDEADBEEF. Same read with `re1`=0 → `rdata1`=0.
- $0 protection: write $0 ← 0xFFFFFFFF, then read $0 on both ports → 0x00000000.
- Same-cycle hazard: $7 holds 0x11111111. Write $7 ← 0x22222222 while `raddr1`=`raddr2`=7 in the same cycle. With `REGFILE_BYPASS_EN`, both ports return 0x22222222; without it, both return 0x11111111. The next cycle returns 0x22222222 in both builds.
- Reset priority: assert `rst`=1 with `we`=1, `waddr`=3, `wdata`=0x12345678 → outputs are 0 during reset, and $3 reads 0 after reset is released.
- Random: 10k cycles of random writes and reads on both ports against a reference model, with 1-cycle reset pulses at random points → zero mismatches.
